// File: rtl/shift_seq_ctrl_if.sv
// Handshake/bus bundle between the serial shift controller, its upstream word source,
// the external 4-bit right-shift register and the downstream serial sink.
interface shift_seq_ctrl_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       flush;
    logic       sr_load;
    logic [3:0] sr_data;
    logic       sr_ena;
    logic       sr_q0;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
    logic       out_ready;
    logic [7:0] word_cnt;

    modport master (
        input  in_valid, in_data, flush, sr_q0, out_ready,
        output in_ready, sr_load, sr_data, sr_ena, out_valid, out_bit, out_last, word_cnt
    );
    modport slave (
        output in_valid, in_data, flush, sr_q0, out_ready,
        input  in_ready, sr_load, sr_data, sr_ena, out_valid, out_bit, out_last, word_cnt
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequences an external right-shift register to serialise 4-bit words LSB first.
// Optional SHIFT_SEQ_CTRL_PARITY_EN appends an even-parity beat after the data beats.
module shift_seq_ctrl #(
    parameter int SHIFTS = 4
) (
    input  logic            clk,
    input  logic            areset,
    shift_seq_ctrl_if.master bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [2:0] LAST_DATA = 3'(SHIFTS - 1);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    localparam logic [2:0] LAST_BEAT = 3'(SHIFTS);
`else
    localparam logic [2:0] LAST_BEAT = LAST_DATA;
`endif

    state_t     state_q, state_d;
    logic [2:0] beat_q, beat_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       last, data_beat;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    logic       par_q, par_d;
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wcnt_q  <= '0;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        wcnt_d        = wcnt_q;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        par_d         = par_q;
        data_beat     = (beat_q <= LAST_DATA);
`else
        data_beat     = 1'b1;
`endif
        last          = (beat_q == LAST_BEAT);
        bus.in_ready  = 1'b0;
        bus.sr_load   = 1'b0;
        bus.sr_data   = bus.in_data;
        bus.sr_ena    = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_bit   = bus.sr_q0;
        bus.out_last  = 1'b0;
        bus.word_cnt  = wcnt_q;

        case (state_q)
            IDLE: begin
                // flush is ignored here so an abort never blocks the next accept
                bus.in_ready = 1'b1;
                bus.sr_load  = bus.in_valid;
                if (bus.in_valid) begin
                    beat_d  = '0;
                    state_d = SHIFT;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
                    par_d   = ^bus.in_data;
`endif
                end
            end
            SHIFT: begin
                bus.out_valid = 1'b1;
                bus.out_last  = last;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
                if (!data_beat) bus.out_bit = par_q;
`endif
                // flush beats a simultaneous transfer: no shift, no count
                bus.sr_ena = bus.out_ready & ~bus.flush & data_beat;
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    beat_d = beat_q + 3'd1;
                    if (last) begin
                        state_d = IDLE;
                        if (wcnt_q != 8'hFF) wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: models the external shift register and scoreboards every beat.
module tb_shift_seq_ctrl;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int SH1 = 4;
    localparam int W1  = SH1 + PAR;
    localparam int W2  = 2 + PAR + 1;   // SHIFTS=2 word period incl. IDLE cycle

    typedef struct packed {logic b; logic last; logic par;} beat_t;

    logic clk = 1'b0;
    logic areset;
    int   checks = 0;
    int   errors = 0;
    int   ena_cnt = 0;
    int   exp_wc = 0;
    beat_t q[$];

    shift_seq_ctrl_if b1();
    shift_seq_ctrl_if b2();

    shift_seq_ctrl #(.SHIFTS(SH1)) u1 (.clk(clk), .areset(areset), .bus(b1));
    shift_seq_ctrl #(.SHIFTS(2))   u2 (.clk(clk), .areset(areset), .bus(b2));

    always #5 clk = ~clk;

    // external shift register models
    logic [3:0] sr1, sr2;
    always @(posedge clk or posedge areset) begin
        if (areset) begin
            sr1 <= '0; sr2 <= '0;
        end else begin
            if (b1.sr_load) sr1 <= b1.sr_data; else if (b1.sr_ena) sr1 <= {1'b0, sr1[3:1]};
            if (b2.sr_load) sr2 <= b2.sr_data; else if (b2.sr_ena) sr2 <= {1'b0, sr2[3:1]};
        end
    end
    assign b1.sr_q0 = sr1[0];
    assign b2.sr_q0 = sr2[0];

    // scoreboard monitor on u1, sampled mid-cycle
    always @(negedge clk) begin
        beat_t e;
        logic  exp_ena;
        if (areset) begin
            q.delete();
            exp_wc = 0;
        end else begin
            checks++;
            if (b1.word_cnt !== 8'(exp_wc)) begin
                errors++; $display("FAIL word_cnt: got %0d want %0d", b1.word_cnt, exp_wc);
            end
            checks++;
            if (b1.in_ready !== !b1.out_valid) begin
                errors++; $display("FAIL in_ready_vs_valid: in_ready %b out_valid %b", b1.in_ready, b1.out_valid);
            end
            exp_ena = 1'b0;
            if (b1.out_valid && b1.flush) begin
                q.delete();
            end else if (b1.out_valid) begin
                if (q.size() == 0) begin
                    errors++; $display("FAIL sb_unexpected_beat: got bit %b, want no beat", b1.out_bit);
                end else begin
                    e = q[0];
                    checks++;
                    if (b1.out_bit !== e.b || b1.out_last !== e.last) begin
                        errors++; $display("FAIL sb_beat: got bit %b last %b want bit %b last %b",
                                           b1.out_bit, b1.out_last, e.b, e.last);
                    end
                    if (b1.out_ready) begin
                        void'(q.pop_front());
                        exp_ena = !e.par;
                        if (e.last && exp_wc < 255) exp_wc++;
                    end
                end
            end
            checks++;
            if (b1.sr_ena !== exp_ena) begin
                errors++; $display("FAIL sr_ena: got %b want %b", b1.sr_ena, exp_ena);
            end
            if (b1.sr_ena) ena_cnt++;
            if (b1.sr_load) begin
                for (int i = 0; i < SH1; i++) begin
                    e.b = b1.sr_data[i]; e.last = (PAR == 0) && (i == SH1 - 1); e.par = 1'b0;
                    q.push_back(e);
                end
                if (PAR != 0) begin
                    e.b = ^b1.sr_data; e.last = 1'b1; e.par = 1'b1;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic offer(input logic [3:0] d);
        bit acc = 0;
        b1.in_valid = 1'b1; b1.in_data = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            #2 acc = b1.in_ready;
            tick();
        end
        b1.in_valid = 1'b0;
        if (!acc) begin
            errors++; $display("FAIL offer_timeout: got no accept, want accept of %b", d);
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            #2 done = !b1.out_valid && q.size() == 0;
            tick();
        end
        if (!done) begin
            errors++; $display("FAIL drain_timeout: got busy, want idle");
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        b1.in_valid = 0; b1.in_data = 0; b1.flush = 0; b1.out_ready = 0;
        b2.in_valid = 0; b2.in_data = 0; b2.flush = 0; b2.out_ready = 0;
        #1;
        checks++;
        if ({b1.out_valid, b1.out_last, b1.sr_ena, b1.in_ready} !== 4'b0001 || b1.word_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_state: got v%b l%b e%b r%b wc%0d want v0 l0 e0 r1 wc0",
                               b1.out_valid, b1.out_last, b1.sr_ena, b1.in_ready, b1.word_cnt);
        end
        tick(); tick();
        areset = 1'b0;
    endtask

    task automatic test_basic();
        logic [3:0] d = 4'b1011;
        logic eb;
        ena_cnt = 0;
        b1.out_ready = 1'b1; b1.in_valid = 1'b1; b1.in_data = d;
        #2 checks++;
        if (b1.sr_load !== 1'b1 || b1.sr_data !== d || b1.word_cnt !== 8'd0) begin
            errors++; $display("FAIL basic_accept: got load %b data %b wc %0d want 1 %b 0", b1.sr_load, b1.sr_data, b1.word_cnt, d);
        end
        tick();
        b1.in_valid = 1'b0;
        for (int i = 0; i < W1; i++) begin
            eb = (i < SH1) ? d[i] : ^d;
            #2 checks++;
            if (b1.out_valid !== 1'b1 || b1.out_bit !== eb || b1.out_last !== (i == W1 - 1)) begin
                errors++; $display("FAIL basic_beat%0d: got v%b b%b l%b want v1 b%b l%b",
                                   i, b1.out_valid, b1.out_bit, b1.out_last, eb, (i == W1 - 1));
            end
            tick();
        end
        #2 checks++;
        if (b1.out_valid !== 1'b0 || b1.word_cnt !== 8'd1 || ena_cnt != SH1) begin
            errors++; $display("FAIL basic_done: got v%b wc%0d ena%0d want v0 wc1 ena%0d", b1.out_valid, b1.word_cnt, ena_cnt, SH1);
        end
        tick();
    endtask

    task automatic test_stall();
        ena_cnt = 0;
        offer(4'b0110);
        tick();
        b1.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #2 checks++;
            if (b1.out_valid !== 1'b1 || b1.out_bit !== 1'b1 || b1.sr_ena !== 1'b0 || b1.out_last !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: got v%b b%b e%b l%b want v1 b1 e0 l0",
                                   i, b1.out_valid, b1.out_bit, b1.sr_ena, b1.out_last);
            end
            if (i == 2) b1.out_ready = 1'b1;
            tick();
        end
        drain();
        checks++;
        if (ena_cnt != SH1) begin
            errors++; $display("FAIL stall_ena_count: got %0d want %0d", ena_cnt, SH1);
        end
    endtask

    task automatic test_flush();
        int wc0 = exp_wc;
        offer(4'b1111);
        tick();
        b1.flush = 1'b1; b1.in_valid = 1'b1; b1.in_data = 4'b0001;
        #2 checks++;
        if (b1.sr_ena !== 1'b0 || b1.out_valid !== 1'b1) begin
            errors++; $display("FAIL flush_cycle: got e%b v%b want e0 v1", b1.sr_ena, b1.out_valid);
        end
        tick();
        #2 checks++;
        if (b1.in_ready !== 1'b1 || b1.sr_load !== 1'b1 || b1.word_cnt !== 8'(wc0)) begin
            errors++; $display("FAIL flush_idle: got r%b load%b wc%0d want r1 load1 wc%0d", b1.in_ready, b1.sr_load, b1.word_cnt, wc0);
        end
        tick();
        b1.flush = 1'b0; b1.in_valid = 1'b0;
        drain();
        checks++;
        if (b1.word_cnt !== 8'(wc0 + 1)) begin
            errors++; $display("FAIL flush_next_word: got wc %0d want %0d", b1.word_cnt, wc0 + 1);
        end
    endtask

    task automatic test_reset_mid();
        offer(4'b1010);
        tick();
        #1 areset = 1'b1;
        #1 checks++;
        if (b1.out_valid !== 1'b0 || b1.word_cnt !== 8'd0 || b1.sr_ena !== 1'b0 || b1.out_last !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got v%b wc%0d e%b l%b want v0 wc0 e0 l0", b1.out_valid, b1.word_cnt, b1.sr_ena, b1.out_last);
        end
        tick(); tick();
        areset = 1'b0;
        #2 checks++;
        if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release: got r%b v%b want r1 v0", b1.in_ready, b1.out_valid);
        end
        tick();
        offer(4'b1100);
        drain();
        checks++;
        if (b1.word_cnt !== 8'd1) begin
            errors++; $display("FAIL reset_fresh_word: got wc %0d want 1", b1.word_cnt);
        end
    endtask

    task automatic test_back_to_back();
        offer(4'b0101);
        b1.in_valid = 1'b1; b1.in_data = 4'b1001;
        for (int i = 0; i < W1; i++) begin
            #2 checks++;
            if (b1.sr_load !== 1'b0 || b1.in_ready !== 1'b0) begin
                errors++; $display("FAIL pending_hold%0d: got load%b r%b want load0 r0", i, b1.sr_load, b1.in_ready);
            end
            tick();
        end
        #2 checks++;
        if (b1.sr_load !== 1'b1 || b1.sr_data !== 4'b1001) begin
            errors++; $display("FAIL pending_accept: got load%b data%b want load1 data1001", b1.sr_load, b1.sr_data);
        end
        tick();
        b1.in_valid = 1'b0;
        drain();
    endtask

    task automatic test_saturate();
        int nacc = 0, last_c = 0;
        b2.out_ready = 1'b1; b2.in_valid = 1'b1; b2.in_data = 4'($urandom);
        for (int c = 0; c < 256 * W2 + 20 && nacc < 256; c++) begin
            #2 if (b2.sr_load) begin
                if (nacc > 0) begin
                    checks++;
                    if (c - last_c != W2) begin
                        errors++; $display("FAIL sat_period: got %0d cycles want %0d", c - last_c, W2);
                    end
                end
                nacc++; last_c = c;
                if (nacc == 256) begin
                    checks++;
                    if (b2.word_cnt !== 8'd255) begin
                        errors++; $display("FAIL sat_255_words: got wc %0d want 255", b2.word_cnt);
                    end
                end
            end
            tick();
            b2.in_data = 4'($urandom);
            if (nacc == 256) b2.in_valid = 1'b0;
        end
        if (nacc != 256) begin
            errors++; $display("FAIL sat_timeout: got %0d accepts want 256", nacc);
        end
        for (int i = 0; i < W2 + 1; i++) tick();
        checks++;
        if (b2.word_cnt !== 8'd255 || b2.out_valid !== 1'b0) begin
            errors++; $display("FAIL sat_hold: got wc %0d v%b want wc 255 v0", b2.word_cnt, b2.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
